// File: rtl/enemy_group.sv
// enemy_group: drives NUM_ENEMIES autonomous arena enemies, each with its own
// movement FSM, plus shared speed-up, hit counting and bomberman contact.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   x, y              current VGA pixel
//   x_b, y_b          bomberman sprite top-left
//   exp_on            explosion tile drawn at the current pixel
//   post_exp_active   explosion still active (holds enemies in HIT)
//   enemy_on          pixel lies within any enemy sprite (combinational)
//   enemy_idx         lowest-index enemy at the pixel, 0 when none
//   sprite_addr       registered enemy sprite ROM address
//   enemy_hit         one-cycle pulse per enemy on entering HIT
//   bm_collide        registered live-enemy / bomberman hitbox overlap
//   hit_count         total hits, saturating at 255
module enemy_group #(
  parameter int unsigned NUM_ENEMIES = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned COLS        = 33,
  parameter int unsigned ROWS        = 26,
  parameter int unsigned X_WALL_L    = 48,
  parameter int unsigned Y_WALL_U    = 32,
  parameter int unsigned TIMER_MAX   = 40000000,
  parameter int unsigned TIMER_MIN   = 4000000,
  parameter int unsigned TIMER_DEC   = 2000000,
  parameter logic [63:0] INIT_TILES  = {8'd10, 8'd12, 8'd20, 8'd4, 8'd30, 8'd22, 8'd2, 8'd24},
  parameter logic [15:0] LFSR_SEED   = 16'hC2E0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [9:0]             x_b,
  input  logic [9:0]             y_b,
  input  logic                   exp_on,
  input  logic                   post_exp_active,
  output logic                   enemy_on,
  output logic [IDX_W-1:0]       enemy_idx,
  output logic [11:0]            sprite_addr,
  output logic [NUM_ENEMIES-1:0] enemy_hit,
  output logic                   bm_collide,
  output logic [7:0]             hit_count
);

  typedef enum logic [2:0] {S_IDLE, S_GET_DIR, S_CHECK, S_MOVE, S_HIT, S_RESPAWN} state_t;
  typedef enum logic [1:0] {D_U, D_R, D_D, D_L} dir_t;

  // Enemy 0 occupies the most significant {col,row} pair.
  function automatic logic [9:0] spawn_x(int unsigned i);
    logic [63:0] t;
    t = INIT_TILES << (16 * i);
    return 10'(X_WALL_L) + {t[61:56], 4'h0};
  endfunction

  function automatic logic [9:0] spawn_y(int unsigned i);
    logic [63:0] t;
    t = INIT_TILES << (16 * i);
    return 10'(Y_WALL_U) + {t[53:48], 4'h0} - 10'd8;
  endfunction

  state_t      r_state [NUM_ENEMIES];
  state_t      w_state_n [NUM_ENEMIES];
  dir_t        r_dir [NUM_ENEMIES];
  dir_t        w_dir_n [NUM_ENEMIES];
  dir_t        w_first [NUM_ENEMIES];
  logic [9:0]  r_x [NUM_ENEMIES];
  logic [9:0]  r_y [NUM_ENEMIES];
  logic [9:0]  w_x_n [NUM_ENEMIES];
  logic [9:0]  w_y_n [NUM_ENEMIES];
  logic [25:0] r_timer [NUM_ENEMIES];
  logic [25:0] w_timer_n [NUM_ENEMIES];
  logic [3:0]  r_step [NUM_ENEMIES];
  logic [3:0]  w_step_n [NUM_ENEMIES];
  logic [2:0]  r_fail [NUM_ENEMIES];
  logic [2:0]  w_fail_n [NUM_ENEMIES];
  logic [9:0]  w_dx [NUM_ENEMIES];
  logic [9:0]  w_dy [NUM_ENEMIES];
  logic [9:0]  w_ox [NUM_ENEMIES];
  logic [9:0]  w_oy [NUM_ENEMIES];
  logic [9:0]  w_tx [NUM_ENEMIES];
  logic [9:0]  w_ty [NUM_ENEMIES];
  logic [3:0]  w_legal [NUM_ENEMIES];
  logic [15:0] w_rnd [NUM_ENEMIES];

  logic [NUM_ENEMIES-1:0] w_in, w_live, w_hit_now, w_ovl, r_hit;
  logic [25:0]            r_tmax, w_tmax_n;
  logic [15:0]            r_lfsr;
  logic [7:0]             r_cnt, w_cnt_n;
  logic [8:0]             w_sum;
  logic                   r_bm, w_on;
  logic [IDX_W-1:0]       w_idx;
  logic [11:0]            r_addr, w_addr;
  logic [9:0]             w_sel_dx, w_sel_dy, w_col;
  dir_t                   w_sel_dir;
  state_t                 w_sel_state;
  logic [3:0]             w_sel_step;
  logic [7:0]             w_off;

  // Per-enemy geometry: sprite hit test, hitbox overlap, tile legality.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      w_dx[i]      = x - r_x[i];
      w_dy[i]      = y - r_y[i];
      w_in[i]      = (w_dx[i] < 10'd16) && (w_dy[i] < 10'd24);
      w_live[i]    = (r_state[i] != S_HIT) && (r_state[i] != S_RESPAWN);
      w_hit_now[i] = exp_on && w_in[i] && w_live[i];
      // Both hitboxes sit 8 below their sprite, so the offset cancels.
      w_ox[i]      = r_x[i] - x_b + 10'd15;
      w_oy[i]      = r_y[i] - y_b + 10'd15;
      w_ovl[i]     = w_live[i] && (w_ox[i] < 10'd31) && (w_oy[i] < 10'd31);
      w_tx[i]      = r_x[i] - 10'(X_WALL_L);
      w_ty[i]      = r_y[i] + 10'd8 - 10'(Y_WALL_U);
      w_legal[i]   = {~w_ty[i][4] && (w_tx[i][9:4] != 6'd0),
                      ~w_tx[i][4] && (w_ty[i][9:4] < 6'(ROWS - 1)),
                      ~w_ty[i][4] && (w_tx[i][9:4] < 6'(COLS - 1)),
                      ~w_tx[i][4] && (w_ty[i][9:4] != 6'd0)};
      if (w_legal[i][0])      w_first[i] = D_U;
      else if (w_legal[i][1]) w_first[i] = D_R;
      else if (w_legal[i][2]) w_first[i] = D_D;
      else                    w_first[i] = D_L;
      w_rnd[i] = r_lfsr >> (2 * i);
    end
  end

  // Next-state and datapath for every enemy FSM plus shared counters.
  always_comb begin
    w_tmax_n = r_tmax;
    w_sum    = {1'b0, r_cnt};
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      w_state_n[i] = r_state[i];
      w_dir_n[i]   = r_dir[i];
      w_x_n[i]     = r_x[i];
      w_y_n[i]     = r_y[i];
      w_timer_n[i] = r_timer[i];
      w_step_n[i]  = r_step[i];
      w_fail_n[i]  = r_fail[i];
      w_sum        = w_sum + 9'(w_hit_now[i]);
      if (w_hit_now[i]) begin
        w_state_n[i] = S_HIT;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            // >= so an enemy whose timer is already beyond a freshly lowered
            // timer_max steps at once instead of waiting for the 26-bit wrap.
            if (r_timer[i] >= r_tmax) begin
              w_timer_n[i] = '0;
              w_state_n[i] = (r_step[i] != 4'd0) ? S_MOVE : S_GET_DIR;
            end else begin
              w_timer_n[i] = r_timer[i] + 26'd1;
            end
          end
          S_GET_DIR: begin
            if (w_rnd[i][4:2] == 3'd0) w_dir_n[i] = dir_t'(w_rnd[i][1:0]);
            w_state_n[i] = S_CHECK;
          end
          S_CHECK: begin
            if (w_legal[i][r_dir[i]]) begin
              w_fail_n[i]  = '0;
              w_state_n[i] = S_MOVE;
            end else if (r_fail[i] == 3'd7) begin
              // Seven rejected picks: stop rolling and take the first legal way.
              w_dir_n[i]   = w_first[i];
              w_fail_n[i]  = '0;
              w_state_n[i] = S_MOVE;
            end else begin
              w_fail_n[i]  = r_fail[i] + 3'd1;
              w_state_n[i] = S_GET_DIR;
            end
          end
          S_MOVE: begin
            case (r_dir[i])
              D_U:     w_y_n[i] = r_y[i] - 10'd1;
              D_R:     w_x_n[i] = r_x[i] + 10'd1;
              D_D:     w_y_n[i] = r_y[i] + 10'd1;
              default: w_x_n[i] = r_x[i] - 10'd1;
            endcase
            w_step_n[i]  = r_step[i] + 4'd1;
            w_state_n[i] = S_IDLE;
          end
          S_HIT: begin
            if (!post_exp_active) w_state_n[i] = S_RESPAWN;
          end
          default: begin
            w_x_n[i]     = spawn_x(i);
            w_y_n[i]     = spawn_y(i);
            w_dir_n[i]   = D_U;
            w_step_n[i]  = '0;
            w_timer_n[i] = '0;
            w_state_n[i] = S_IDLE;
            if (w_tmax_n >= 26'(TIMER_MIN + TIMER_DEC)) w_tmax_n = w_tmax_n - 26'(TIMER_DEC);
            else                                         w_tmax_n = 26'(TIMER_MIN);
          end
        endcase
      end
    end
    w_cnt_n = w_sum[8] ? 8'hFF : w_sum[7:0];
  end

  // Pixel priority and sprite ROM address for the lowest-index enemy hit.
  always_comb begin
    w_on        = 1'b0;
    w_idx       = '0;
    w_sel_dx    = w_dx[0];
    w_sel_dy    = w_dy[0];
    w_sel_dir   = r_dir[0];
    w_sel_state = r_state[0];
    w_sel_step  = r_step[0];
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      if (w_in[i] && !w_on) begin
        w_on        = 1'b1;
        w_idx       = IDX_W'(i);
        w_sel_dx    = w_dx[i];
        w_sel_dy    = w_dy[i];
        w_sel_dir   = r_dir[i];
        w_sel_state = r_state[i];
        w_sel_step  = r_step[i];
      end
    end
    if (w_sel_state == S_HIT) begin
      w_off = 8'd216;
    end else begin
      case (w_sel_dir)
        D_U:     w_off = 8'd0;
        D_D:     w_off = 8'd144;
        default: w_off = 8'd72;
      endcase
      if (w_sel_step[3:2] == 2'd1)      w_off = w_off + 8'd24;
      else if (w_sel_step[3:2] == 2'd3) w_off = w_off + 8'd48;
    end
    w_col  = (w_sel_dir == D_L) ? 10'd15 - w_sel_dx : w_sel_dx;
    w_addr = {2'b00, w_col} + (({2'b00, w_sel_dy} + {4'h0, w_off}) << 4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        r_state[i] <= S_IDLE;
        r_dir[i]   <= D_U;
        r_x[i]     <= spawn_x(i);
        r_y[i]     <= spawn_y(i);
        r_timer[i] <= '0;
        r_step[i]  <= '0;
        r_fail[i]  <= '0;
      end
      r_tmax <= 26'(TIMER_MAX);
      r_lfsr <= LFSR_SEED;
      r_cnt  <= '0;
      r_hit  <= '0;
      r_bm   <= 1'b0;
      r_addr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        r_state[i] <= w_state_n[i];
        r_dir[i]   <= w_dir_n[i];
        r_x[i]     <= w_x_n[i];
        r_y[i]     <= w_y_n[i];
        r_timer[i] <= w_timer_n[i];
        r_step[i]  <= w_step_n[i];
        r_fail[i]  <= w_fail_n[i];
      end
      r_tmax <= w_tmax_n;
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_cnt  <= w_cnt_n;
      r_hit  <= w_hit_now;
      r_bm   <= |w_ovl;
      r_addr <= w_addr;
    end
  end

  assign enemy_on    = w_on;
  assign enemy_idx   = w_idx;
  assign sprite_addr = r_addr;
  assign enemy_hit   = r_hit;
  assign bm_collide  = r_bm;
  assign hit_count   = r_cnt;

endmodule

// File: tb/tb_enemy_group.sv
// Randomised scoreboard bench for enemy_group. A behavioural model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_enemy_group;
  localparam int N    = 3;
  localparam int TMAX = 6;
  localparam int TMIN = 1;
  localparam int TDEC = 2;
  localparam int XL   = 48;
  localparam int YU   = 32;
  localparam int COLS = 33;
  localparam int ROWS = 26;
  localparam int NCYC = 24000;
  // Enemies 0 and 2 share a spawn tile so priority and multi-hits occur.
  localparam logic [63:0] TILES = {8'd10, 8'd12, 8'd20, 8'd4, 8'd10, 8'd12, 8'd2, 8'd24};
  localparam int WAIT = 0, PICK = 1, TEST = 2, STEP = 3, STUN = 4, REBORN = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0, y = '0, x_b = '0, y_b = '0;
  logic       exp_on = 1'b0, post_exp_active = 1'b0;
  logic       enemy_on, bm_collide;
  logic [1:0] enemy_idx;
  logic [11:0] sprite_addr;
  logic [2:0] enemy_hit;
  logic [7:0] hit_count;

  enemy_group #(.NUM_ENEMIES(N), .IDX_W(2), .TIMER_MAX(TMAX), .TIMER_MIN(TMIN),
                .TIMER_DEC(TDEC), .INIT_TILES(TILES)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .x_b(x_b), .y_b(y_b),
    .exp_on(exp_on), .post_exp_active(post_exp_active),
    .enemy_on(enemy_on), .enemy_idx(enemy_idx), .sprite_addr(sprite_addr),
    .enemy_hit(enemy_hit), .bm_collide(bm_collide), .hit_count(hit_count));

  always #5 clk = ~clk;

  typedef struct {int on; int idx; int addr; int hit; int bm; int cnt;} rec_t;
  rec_t q[$];
  int n_chk = 0, n_fail = 0;
  bit running = 0;

  // Model state
  int ex[N], ey[N], ed[N], et[N], es[N], ef[N], ph[N];
  int tmax, cnt, lfsr, e_hit, e_bm, e_addr;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic int spawn_x(int i);
    logic [63:0] t;
    t = TILES >> (56 - 16 * i);
    return (XL + 16 * int'(t[7:0])) & 1023;
  endfunction

  function automatic int spawn_y(int i);
    logic [63:0] t;
    t = TILES >> (48 - 16 * i);
    return (YU + 16 * int'(t[7:0]) - 8) & 1023;
  endfunction

  function automatic bit inspr(int i, int px, int py);
    return (((px - ex[i]) & 1023) < 16) && (((py - ey[i]) & 1023) < 24);
  endfunction

  function automatic bit near(int a, int b);
    int d;
    d = (a - b) & 1023;
    return (d <= 15) || (d >= 1009);
  endfunction

  function automatic bit legal(int i, int d);
    int c, r;
    c = ((ex[i] - XL) & 1023) / 16;
    r = ((ey[i] + 8 - YU) & 1023) / 16;
    case (d)
      0: return (c % 2 == 0) && (r > 0);
      1: return (r % 2 == 0) && (c < COLS - 1);
      2: return (c % 2 == 0) && (r < ROWS - 1);
      default: return (r % 2 == 0) && (c > 0);
    endcase
  endfunction

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      ex[i] = spawn_x(i); ey[i] = spawn_y(i);
      ed[i] = 0; et[i] = 0; es[i] = 0; ef[i] = 0; ph[i] = WAIT;
    end
    tmax = TMAX; cnt = 0; lfsr = 16'hC2E0; e_hit = 0; e_bm = 0; e_addr = 0;
  endtask

  task automatic model_step(input int px, input int py, input int bx, input int by,
                            input int eo, input int pea);
    int nx[N], ny[N], nd[N], nt[N], ns[N], nf[N], np[N];
    int mask, nh, bm, sel, found, off, col, row, ntmax, f, fb;
    bit live;
    mask = 0; nh = 0; bm = 0; sel = 0; found = 0;
    for (int i = 0; i < N; i++) begin
      live = (ph[i] != STUN) && (ph[i] != REBORN);
      if (inspr(i, px, py) && found == 0) begin sel = i; found = 1; end
      if (eo != 0 && live && inspr(i, px, py)) begin mask |= (1 << i); nh++; end
      if (live && near(ex[i], bx) && near(ey[i], by)) bm = 1;
    end
    if (ph[sel] == STUN) off = 216;
    else begin
      off = (ed[sel] == 0) ? 0 : (ed[sel] == 2) ? 144 : 72;
      if ((es[sel] / 4) == 1) off += 24;
      else if ((es[sel] / 4) == 3) off += 48;
    end
    col = (px - ex[sel]) & 1023;
    if (ed[sel] == 3) col = (15 - col) & 1023;
    row = (py - ey[sel]) & 1023;
    ntmax = tmax;
    for (int i = 0; i < N; i++) begin
      nx[i] = ex[i]; ny[i] = ey[i]; nd[i] = ed[i]; nt[i] = et[i];
      ns[i] = es[i]; nf[i] = ef[i]; np[i] = ph[i];
      if (((mask >> i) & 1) != 0) np[i] = STUN;
      else case (ph[i])
        WAIT: if (et[i] >= tmax) begin
                nt[i] = 0; np[i] = (es[i] != 0) ? STEP : PICK;
              end else nt[i] = et[i] + 1;
        PICK: begin
          f = (lfsr >> (2 + 2 * i)) & 7;
          if (f == 0) nd[i] = (lfsr >> (2 * i)) & 3;
          np[i] = TEST;
        end
        TEST: if (legal(i, ed[i])) begin
                np[i] = STEP; nf[i] = 0;
              end else if (ef[i] == 7) begin
                for (int d = 3; d >= 0; d--) if (legal(i, d)) nd[i] = d;
                nf[i] = 0; np[i] = STEP;
              end else begin
                nf[i] = ef[i] + 1; np[i] = PICK;
              end
        STEP: begin
          case (ed[i])
            0: ny[i] = (ey[i] + 1023) % 1024;
            1: nx[i] = (ex[i] + 1) % 1024;
            2: ny[i] = (ey[i] + 1) % 1024;
            default: nx[i] = (ex[i] + 1023) % 1024;
          endcase
          ns[i] = (es[i] + 1) % 16; np[i] = WAIT;
        end
        STUN: if (pea == 0) np[i] = REBORN;
        default: begin
          nx[i] = spawn_x(i); ny[i] = spawn_y(i); nd[i] = 0; ns[i] = 0; nt[i] = 0;
          np[i] = WAIT;
          ntmax = (ntmax - TDEC >= TMIN) ? ntmax - TDEC : TMIN;
        end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      ex[i] = nx[i]; ey[i] = ny[i]; ed[i] = nd[i]; et[i] = nt[i];
      es[i] = ns[i]; ef[i] = nf[i]; ph[i] = np[i];
    end
    tmax = ntmax;
    cnt = (cnt + nh > 255) ? 255 : cnt + nh;
    e_hit = mask; e_bm = bm; e_addr = (col + (row + off) * 16) % 4096;
    fb = ((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1;
    lfsr = ((lfsr << 1) | fb) & 16'hFFFF;
  endtask

  // Monitor: compares DUT outputs with the oldest expected record.
  always @(negedge clk) begin
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("enemy_on", int'(enemy_on), r.on);
      chk("enemy_idx", int'(enemy_idx), r.idx);
      chk("sprite_addr", int'(sprite_addr), r.addr);
      chk("enemy_hit", int'(enemy_hit), r.hit);
      chk("bm_collide", int'(bm_collide), r.bm);
      chk("hit_count", int'(hit_count), r.cnt);
    end else if (running) begin
      chk("record_present", 0, 1);
    end
  end

  initial begin
    int px, py, bx, by, eo, pea, t, storm;
    int p_px, p_py, p_bx, p_by, p_eo, p_pea;
    bit p_rst, rst;
    rec_t r;
    model_init();
    p_rst = 1; p_px = 0; p_py = 0; p_bx = 0; p_by = 0; p_eo = 0; p_pea = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      if (p_rst) model_init();
      else model_step(p_px, p_py, p_bx, p_by, p_eo, p_pea);
      #1;
      storm = (k / 400) % 2;
      rst = (k < 3) || (k >= 12000 && k < 12002);
      t = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) != 0) begin
        px = (ex[t] + int'($urandom_range(0, 19)) - 2) & 1023;
        py = (ey[t] + int'($urandom_range(0, 27)) - 2) & 1023;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      t = int'($urandom_range(0, N - 1));
      bx = (ex[t] + int'($urandom_range(0, 40)) - 20) & 1023;
      by = (ey[t] + int'($urandom_range(0, 40)) - 20) & 1023;
      eo = (storm != 0) ? int'($urandom_range(0, 2) == 0) : int'($urandom_range(0, 39) == 0);
      pea = int'($urandom_range(0, 1));
      reset = rst; x = px[9:0]; y = py[9:0]; x_b = bx[9:0]; y_b = by[9:0];
      exp_on = eo[0]; post_exp_active = pea[0];
      if (rst) model_init();
      r.on = 0; r.idx = 0;
      for (int i = 0; i < N; i++)
        if (inspr(i, px, py) && r.on == 0) begin r.on = 1; r.idx = i; end
      r.addr = e_addr; r.hit = e_hit; r.bm = e_bm; r.cnt = cnt;
      q.push_back(r);
      running = 1;
      p_rst = rst; p_px = px; p_py = py; p_bx = bx; p_by = by; p_eo = eo; p_pea = pea;
    end
    running = 0;
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/enemy_group.md
Name: enemy_group

Overview:
- Drives NUM_ENEMIES autonomous arena enemies from one block, each with its own movement FSM; this is the multi-enemy, parametrised successor of the single-enemy controller.
- Sits between the VGA pixel pipeline and the top-level game logic.
- Outputs pixel hit/priority, sprite ROM address, explosion-hit pulses and a bomberman-contact flag.
- Adds behaviour the single-enemy version lacks: respawn after a hit, progressive speed-up, hit counting and bomberman collision detection.

Parameters:
- NUM_ENEMIES, 3, number of enemies (1..4).
- IDX_W, 2, width of enemy index output.
- COLS, 33, arena tile columns.
- ROWS, 26, arena tile rows.
- X_WALL_L, 48, arena left pixel x.
- Y_WALL_U, 32, arena top pixel y.
- TIMER_MAX, 40000000, initial ticks per pixel step.
- TIMER_MIN, 4000000, floor for the step period.
- TIMER_DEC, 2000000, step-period reduction per hit.
- INIT_TILES, {8'd10,8'd12, 8'd20,8'd4, 8'd30,8'd22, 8'd2,8'd24}, packed {col,row} spawn tile per enemy, enemy 0 first; all even/even.
- LFSR_SEED, 16'hC2E0, non-zero seed of the internal 16-bit LFSR.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- x, in, 10, current pixel x.
- y, in, 10, current pixel y.
- x_b, in, 10, bomberman sprite top-left x.
- y_b, in, 10, bomberman sprite top-left y.
- exp_on, in, 1, explosion tile drawn at current pixel.
- post_exp_active, in, 1, explosion still active.
- enemy_on, out, 1, pixel lies within any enemy sprite.
- enemy_idx, out, IDX_W, lowest-index enemy at the pixel.
- sprite_addr, out, 12, enemy sprite ROM address.
- enemy_hit, out, NUM_ENEMIES, one-cycle pulse per enemy on entering HIT.
- bm_collide, out, 1, registered: a live enemy hitbox overlaps bomberman's hitbox.
- hit_count, out, 8, total hits, saturating at 255.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Geometry:
  - Sprite is 16x24; hitbox is the lower 16x16.
  - Tile (c,r) maps to sprite x = X_WALL_L + 16c, y = Y_WALL_U + 16r − 8.
  - Pillars occupy odd/odd tiles.
- Per-enemy state: x, y (10b), dir (U=0 y−1, R=1 x+1, D=2 y+1, L=3 x−1), timer (26b), step_cnt (4b), fail_cnt (3b), FSM.
- Shared state: timer_max (26b).
- Reset values:
  - Each enemy at its INIT_TILES tile, dir=U, timer=0, step_cnt=0, FSM=IDLE.
  - timer_max=TIMER_MAX, hit_count=0.
  - enemy_hit=0, bm_collide=0, sprite_addr=0.
  - LFSR=LFSR_SEED; LFSR advances every cycle.
  - A reset mid-operation restores all of the above immediately.
- FSM states:
  - IDLE:
    - timer++ each cycle.
    - When timer==timer_max: timer←0; go MOVE if step_cnt≠0, else GET_DIR.
  - GET_DIR:
    - If lfsr[4+2i:2+2i]==0, dir←lfsr[1+2i:2i] (i = enemy index); otherwise keep dir.
    - Go CHECK.
  - CHECK:
    - Using tile (c,r) = current tile:
      - U legal iff c even and r>0.
      - D legal iff c even and r<ROWS−1.
      - L legal iff r even and c>0.
      - R legal iff r even and c<COLS−1.
    - Legal → MOVE, fail_cnt←0.
    - Illegal → fail_cnt++ and go GET_DIR.
    - When fail_cnt reaches 7: dir←next legal dir in order U,R,D,L, go MOVE.
  - MOVE:
    - Apply a one-pixel step in dir.
    - step_cnt++ (15 wraps to 0, which marks tile-aligned).
    - Go IDLE.
  - HIT:
    - Entry from any state except HIT/RESPAWN, when exp_on and (x,y) lies in this enemy's sprite.
    - This takes priority over a same-cycle move.
    - On entry: enemy_hit[i] pulses for one cycle; hit_count++ (saturating).
    - Leave when post_exp_active==0 → RESPAWN.
  - RESPAWN:
    - Restore the INIT tile; dir=U, step_cnt=0, timer=0.
    - timer_max ← max(timer_max−TIMER_DEC, TIMER_MIN).
    - Go IDLE.
  - Simultaneous hits: every qualifying enemy enters HIT; hit_count adds the number of enemies hit that cycle, saturating.
- Enemy is live when not in HIT/RESPAWN.
- bm_collide: registered OR over live enemies of 16x16 overlap between the enemy hitbox (x, y+8) and bomberman hitbox (x_b, y_b+8); latency 1 cycle.
- enemy_on / enemy_idx: combinational; enemy_idx is the lowest matching index, or 0 when none.
- Sprite frame offset (registered, 1-cycle latency):
  - HIT → 216.
  - step_cnt[3:2]==1 → frame 2.
  - step_cnt[3:2]==3 → frame 3.
  - Otherwise → frame 1.
  - Base offset: U=0, R/L=72, D=144; frames are +0, +24, +48.
- sprite_addr = col + ((row+offset)<<4), with col = x−x_e, row = y−y_e; for dir L, col = 15−(x−x_e).
- Width rule: all coordinate arithmetic is 10-bit modulo.

Test Plan:
- Reset, TIMER_MAX overridden to 4: enemy 0 at (208,216), dir U; first pixel step after 5 IDLE cycles; tile change after 16 steps; step_cnt back to 0.
- Force enemy 0 to tile (1,2) (odd col) with dir U → CHECK illegal; enemy either moves horizontally or hits the fail_cnt=7 fallback; never moves vertically.
- exp_on with pixel inside enemy 1 → enemy_hit=3'b010 for one cycle, hit_count=1; post_exp_active drops → enemy 1 back at its spawn tile, timer_max=TIMER_MAX−TIMER_DEC.
- Eighteen consecutive hits → timer_max clamps at TIMER_MIN=4000000.
- Bomberman at the enemy 0 position → bm_collide=1 one cycle later; enemy 0 in HIT → bm_collide=0.
- Enemies 0 and 2 overlapping at the pixel → enemy_on=1, enemy_idx=0; dir L → sprite_addr column mirrored (x−x_e=0 gives col 15).
